dmem_rv: RTL



---
 rtl/rv_mem_pkg.sv | 22 ++
 rtl/dmem_mmio_rv.sv | 98 +++++++++
 rtl/dmem_rv.sv | 79 +++++++
 3 files changed

// File: rtl/rv_mem_pkg.sv
// Shared constants and types for the data-side memory responder:
// register-window offsets, reset values and the address region type.
package rv_mem_pkg;

    // Word offsets inside the 16-byte register window (byte offset >> 2)
    localparam logic [1:0] OFF_MTIME    = 2'd0;
    localparam logic [1:0] OFF_MTIMECMP = 2'd1;
    localparam logic [1:0] OFF_TOHOST   = 2'd2;
    localparam logic [1:0] OFF_STATUS   = 2'd3;

    localparam logic [31:0] MTIMECMP_RST = 32'hFFFF_FFFF;

    localparam int STATUS_IRQ_BIT = 0;
    localparam int STATUS_ERR_BIT = 1;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_UNMAPPED
    } region_e;

endpackage

// File: rtl/dmem_mmio_rv.sv
// Register window: free-running timer, compare/irq, host mailbox and
// sticky error/status, plus the window's combinational read mux.
module dmem_mmio_rv
    import rv_mem_pkg::*;
#(
    parameter int BITWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                sel,
    input  logic                we,
    input  logic [1:0]          off,
    input  logic [BITWIDTH-1:0] wdata,
    input  logic                err_set,
    output logic [BITWIDTH-1:0] rdata,
    output logic                tohost_valid,
    output logic [BITWIDTH-1:0] tohost_data,
    output logic                timer_irq,
    output logic                err
);

    logic [BITWIDTH-1:0] mtime_q, mtime_d;
    logic [BITWIDTH-1:0] mtimecmp_q, mtimecmp_d;
    logic [BITWIDTH-1:0] tohost_data_q, tohost_data_d;
    logic                tohost_valid_q, tohost_valid_d;
    logic                timer_irq_q, timer_irq_d;
    logic                err_q, err_d;
    logic                wr;

    assign wr = en && we && sel;

    always_comb begin
        mtime_d        = mtime_q;
        mtimecmp_d     = mtimecmp_q;
        tohost_data_d  = tohost_data_q;
        tohost_valid_d = tohost_valid_q;
        timer_irq_d    = timer_irq_q;
        err_d          = err_q;

        if (en) begin
            mtime_d        = mtime_q + BITWIDTH'(1);
            timer_irq_d    = (mtime_q >= mtimecmp_q);
            tohost_valid_d = wr && (off == OFF_TOHOST);
        end

        // A software write to MTIME replaces this cycle's increment
        if (wr) begin
            case (off)
                OFF_MTIME:    mtime_d       = wdata;
                OFF_MTIMECMP: mtimecmp_d    = wdata;
                OFF_TOHOST:   tohost_data_d = wdata;
                OFF_STATUS:   if (wdata[STATUS_ERR_BIT]) err_d = 1'b0;
                default:      ;
            endcase
        end

        // Setting wins over a clear landing on the same edge
        if (err_set) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime_q        <= '0;
            mtimecmp_q     <= BITWIDTH'(MTIMECMP_RST);
            tohost_data_q  <= '0;
            tohost_valid_q <= 1'b0;
            timer_irq_q    <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            mtime_q        <= mtime_d;
            mtimecmp_q     <= mtimecmp_d;
            tohost_data_q  <= tohost_data_d;
            tohost_valid_q <= tohost_valid_d;
            timer_irq_q    <= timer_irq_d;
            err_q          <= err_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (off)
            OFF_MTIME:    rdata = mtime_q;
            OFF_MTIMECMP: rdata = mtimecmp_q;
            OFF_STATUS: begin
                rdata[STATUS_IRQ_BIT] = timer_irq_q;
                rdata[STATUS_ERR_BIT] = err_q;
            end
            default:      rdata = '0;
        endcase
    end

    assign tohost_valid = tohost_valid_q;
    assign tohost_data  = tohost_data_q;
    assign timer_irq    = timer_irq_q;
    assign err          = err_q;

endmodule

// File: rtl/dmem_rv.sv
// Data memory responder for the core's M stage: word RAM plus register
// window, zero-latency reads, writes committed on the rising edge.
module dmem_rv
    import rv_mem_pkg::*;
#(
    parameter int                 BITWIDTH  = 32,
    parameter int                 DEPTH     = 1024,
    parameter logic [BITWIDTH-1:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                MemWriteM,
    input  logic [BITWIDTH-1:0] ALUResultM,
    input  logic [BITWIDTH-1:0] WriteDataM,
    output logic [BITWIDTH-1:0] ReadDataM,
    output logic                tohost_valid,
    output logic [BITWIDTH-1:0] tohost_data,
    output logic                timer_irq,
    output logic                err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [BITWIDTH-1:0] RAM_LIMIT = BITWIDTH'(4 * DEPTH);

    logic [BITWIDTH-1:0] ram_q [DEPTH];
    logic [BITWIDTH-1:0] mmio_off_addr;
    logic [BITWIDTH-1:0] mmio_rdata;
    logic [AW-1:0]       word_idx;
    region_e             region;
    logic                unmapped_wr;

    assign mmio_off_addr = ALUResultM - MMIO_BASE;
    assign word_idx      = ALUResultM[AW+1:2];

    // Subtracting the base first keeps the window test free of overflow
    always_comb begin
        region = REG_UNMAPPED;
        if (ALUResultM < RAM_LIMIT)
            region = REG_RAM;
        else if (ALUResultM >= MMIO_BASE && mmio_off_addr < BITWIDTH'(16))
            region = REG_MMIO;
    end

    assign unmapped_wr = en && MemWriteM && (region == REG_UNMAPPED);

    always_ff @(posedge clk) begin
        if (en && MemWriteM && region == REG_RAM)
            ram_q[word_idx] <= WriteDataM;
    end

    dmem_mmio_rv #(
        .BITWIDTH (BITWIDTH)
    ) u_mmio (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sel          (region == REG_MMIO),
        .we           (MemWriteM),
        .off          (ALUResultM[3:2]),
        .wdata        (WriteDataM),
        .err_set      (unmapped_wr),
        .rdata        (mmio_rdata),
        .tohost_valid (tohost_valid),
        .tohost_data  (tohost_data),
        .timer_irq    (timer_irq),
        .err          (err)
    );

    always_comb begin
        ReadDataM = '0;
        case (region)
            REG_RAM:  ReadDataM = ram_q[word_idx];
            REG_MMIO: ReadDataM = mmio_rdata;
            default:  ReadDataM = '0;
        endcase
    end

endmodule
